// File: rtl/pool_window_buffer.sv
// pool_window_buffer: re-orders a raster-order feature map into 2x2 pooling
// windows. Even rows are parked in a line buffer; on each odd-row/odd-col
// pixel the four window samples are emitted as a 4-beat burst with a start
// pulse on the first beat, while ready_in throttles upstream.
module pool_window_buffer #(
  parameter int bits       = 8,
  parameter int img_width  = 8,
  parameter int img_height = 8,
  parameter int col_bits   = 3,
  parameter int row_bits   = 3
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [bits-1:0] data_in,
  input  logic            valid_in,
  output logic            ready_in,
  output logic [bits-1:0] data_out,
  output logic            valid_out,
  output logic            start,
  output logic            frame_done
);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [col_bits-1:0] col_q, col_d;
  logic [row_bits-1:0] row_q, row_d;
  logic [bits-1:0]     hold_q, hold_d;
  logic [bits-1:0]     tr_q, tr_d;
  logic [bits-1:0]     br_q, br_d;
  logic [bits-1:0]     data_out_q, data_out_d;
  logic                valid_out_q, valid_out_d;
  logic                start_q, start_d;
  logic                frame_done_q, frame_done_d;
  logic                ready_q, ready_d;

  logic [bits-1:0]     line_buf [img_width];

  logic                accept_s;
  logic                col_last_s;
  logic                row_last_s;
  logic                fire_s;

  assign accept_s   = valid_in && ready_q;
  assign col_last_s = (col_q == col_bits'(img_width - 1));
  assign row_last_s = (row_q == row_bits'(img_height - 1));
  assign fire_s     = accept_s && row_q[0] && col_q[0];

  assign ready_in   = ready_q;
  assign data_out   = data_out_q;
  assign valid_out  = valid_out_q;
  assign start      = start_q;
  assign frame_done = frame_done_q;

  // Line buffer: even-row pixels are parked here until the odd row below arrives.
  always_ff @(posedge clk_in) begin
    if (accept_s && !row_q[0]) begin
      line_buf[col_q] <= data_in;
    end
  end

  // Next-state logic: counters, hold/capture registers and the emission FSM.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    tr_d         = tr_q;
    br_d         = br_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    start_d      = 1'b0;
    frame_done_d = 1'b0;
    ready_d      = ready_q;

    if (accept_s) begin
      if (col_last_s) begin
        col_d = {col_bits{1'b0}};
        if (row_last_s) begin
          row_d        = {row_bits{1'b0}};
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + row_bits'(1);
        end
      end else begin
        col_d = col_q + col_bits'(1);
      end
      if (row_q[0] && !col_q[0]) begin
        hold_d = data_in;
      end else begin
        hold_d = hold_q;
      end
    end else begin
      col_d = col_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fire_s) begin
          // The top-right and bottom-right samples are captured now so a
          // following frame may overwrite the line buffer during the burst.
          state_d     = S_EMIT;
          beat_d      = 2'd0;
          data_out_d  = line_buf[col_q - col_bits'(1)];
          tr_d        = line_buf[col_q];
          br_d        = data_in;
          valid_out_d = 1'b1;
          start_d     = 1'b1;
          ready_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        case (beat_q)
          2'd0: begin
            data_out_d  = tr_q;
            valid_out_d = 1'b1;
            beat_d      = 2'd1;
          end
          2'd1: begin
            data_out_d  = hold_q;
            valid_out_d = 1'b1;
            beat_d      = 2'd2;
          end
          2'd2: begin
            data_out_d  = br_q;
            valid_out_d = 1'b1;
            beat_d      = 2'd3;
            ready_d     = 1'b1;
          end
          2'd3: begin
            state_d = S_IDLE;
            beat_d  = 2'd0;
          end
          default: begin
            state_d = S_IDLE;
            beat_d  = 2'd0;
            ready_d = 1'b1;
          end
        endcase
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = 2'd0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= 2'd0;
      col_q        <= {col_bits{1'b0}};
      row_q        <= {row_bits{1'b0}};
      hold_q       <= {bits{1'b0}};
      tr_q         <= {bits{1'b0}};
      br_q         <= {bits{1'b0}};
      data_out_q   <= {bits{1'b0}};
      valid_out_q  <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      tr_q         <= tr_d;
      br_q         <= br_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed testbench for pool_window_buffer on a 4x4 frame of 8-bit pixels.
module tb_pool_window_buffer;

  logic       clk_in = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       start;
  logic       frame_done;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] beats [$];
  logic       starts [$];
  int         fd_cnt = 0;
  int         stray_start = 0;
  int         stalls [16];
  logic [7:0] pix [16];

  pool_window_buffer #(
    .bits(8), .img_width(4), .img_height(4), .col_bits(2), .row_bits(2)
  ) dut (
    .clk_in(clk_in), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .start(start), .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Output monitor: records beats, start flags and frame_done pulses.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (valid_out) begin
        beats.push_back(data_out);
        starts.push_back(start);
      end else if (start) begin
        stray_start++;
      end
      if (frame_done) fd_cnt++;
    end
  end

  // Raster index of the k-th emitted beat of a 4x4 frame.
  function automatic int exp_idx(input int k);
    int w, j, r, c;
    w = k / 4; j = k % 4;
    r = (w / 2) * 2 + j / 2;
    c = (w % 2) * 2 + j % 2;
    return r * 4 + c;
  endfunction

  // Offer one pixel; returns the number of cycles ready_in was low.
  task automatic push(input logic [7:0] v, input bit junk, output int stall);
    stall = 0;
    valid_in = 1'b1;
    data_in = v;
    while (ready_in !== 1'b1 && stall < 20) begin
      if (junk) data_in = 8'(8'hA5 + stall);
      @(negedge clk_in);
      stall++;
    end
    total++;
    if (stall >= 20) begin
      bad++;
      $display("FAIL push_timeout: ready_in=%b after %0d cycles, required 1", ready_in, stall);
    end
    data_in = v;
    @(negedge clk_in);
  endtask

  task automatic run_frame(input bit toggle, input bit junk);
    int s;
    for (int i = 0; i < 16; i++) begin
      push(pix[i], junk, s);
      stalls[i] = s;
      if (toggle) begin
        valid_in = 1'b0;
        data_in = 8'h5A;
        @(negedge clk_in);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk_in);
  endtask

  task automatic clear_mon();
    beats.delete();
    starts.delete();
    fd_cnt = 0;
    stray_start = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    repeat (3) @(negedge clk_in);
    total++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || start !== 1'b0 ||
        frame_done !== 1'b0 || ready_in !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got d=%h v=%b s=%b fd=%b r=%b, required 00 0 0 0 1",
               data_out, valid_out, start, frame_done, ready_in);
    end
    rst = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    clear_mon();
    run_frame(1'b0, 1'b0);
    total++;
    if (frame_done !== 1'b1) begin
      bad++; $display("FAIL basic_fd_pulse: got %b, required 1", frame_done);
    end
    @(negedge clk_in);
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL basic_fd_width: got %b, required 0", frame_done);
    end
    drain();
    total++;
    if (beats.size() != 16) begin
      bad++; $display("FAIL basic_count: got %0d beats, required 16", beats.size());
    end
    for (int k = 0; k < 16 && k < beats.size(); k++) begin
      total++;
      if (beats[k] !== 8'(exp_idx(k)) || starts[k] !== (k % 4 == 0)) begin
        bad++;
        $display("FAIL basic_beat%0d: got %h start=%b, required %h start=%b",
                 k, beats[k], starts[k], 8'(exp_idx(k)), (k % 4 == 0));
      end
    end
    total++;
    if (fd_cnt != 1 || stray_start != 0) begin
      bad++; $display("FAIL basic_fd_count: got fd=%0d stray=%0d, required 1 0", fd_cnt, stray_start);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    clear_mon();
    run_frame(1'b1, 1'b0);
    drain();
    total++;
    if (beats.size() != 16) begin
      bad++; $display("FAIL toggle_count: got %0d beats, required 16", beats.size());
    end
    for (int k = 0; k < 16 && k < beats.size(); k++) begin
      total++;
      if (beats[k] !== 8'(exp_idx(k)) || starts[k] !== (k % 4 == 0)) begin
        bad++;
        $display("FAIL toggle_beat%0d: got %h start=%b, required %h", k, beats[k], starts[k], 8'(exp_idx(k)));
      end
    end
    total++;
    if (fd_cnt != 1) begin
      bad++; $display("FAIL toggle_fd: got %0d, required 1", fd_cnt);
    end
  endtask

  task automatic test_stall();
    int exp_stall;
    for (int i = 0; i < 16; i++) pix[i] = 8'(8'h20 + i);
    clear_mon();
    run_frame(1'b0, 1'b1);
    drain();
    for (int i = 0; i < 16; i++) begin
      exp_stall = (i == 6 || i == 8 || i == 14) ? 3 : 0;
      total++;
      if (stalls[i] != exp_stall) begin
        bad++; $display("FAIL stall_px%0d: got %0d, required %0d", i, stalls[i], exp_stall);
      end
    end
    total++;
    if (beats.size() != 16) begin
      bad++; $display("FAIL stall_count: got %0d beats, required 16", beats.size());
    end
    for (int k = 0; k < 16 && k < beats.size(); k++) begin
      total++;
      if (beats[k] !== 8'(8'h20 + exp_idx(k))) begin
        bad++; $display("FAIL stall_beat%0d: got %h, required %h", k, beats[k], 8'(8'h20 + exp_idx(k)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    clear_mon();
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) pix[i] = 8'(100 + i);
    run_frame(1'b0, 1'b0);
    drain();
    total++;
    if (beats.size() != 32 || fd_cnt != 2) begin
      bad++; $display("FAIL b2b_count: got %0d beats fd=%0d, required 32 2", beats.size(), fd_cnt);
    end
    for (int k = 0; k < 32 && k < beats.size(); k++) begin
      e = (k < 16) ? 8'(exp_idx(k)) : 8'(100 + exp_idx(k - 16));
      total++;
      if (beats[k] !== e || starts[k] !== (k % 4 == 0)) begin
        bad++; $display("FAIL b2b_beat%0d: got %h start=%b, required %h", k, beats[k], starts[k], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int s;
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    clear_mon();
    for (int i = 0; i < 8; i++) push(pix[i], 1'b0, s);
    total++;
    if (valid_out !== 1'b1 || start !== 1'b1 || data_out !== 8'd2) begin
      bad++; $display("FAIL rstmid_beat1: got v=%b s=%b d=%h, required 1 1 02", valid_out, start, data_out);
    end
    @(negedge clk_in);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'd3) begin
      bad++; $display("FAIL rstmid_beat2: got v=%b d=%h, required 1 03", valid_out, data_out);
    end
    rst = 1'b1; valid_in = 1'b0;
    @(negedge clk_in);
    total++;
    if (valid_out !== 1'b0 || ready_in !== 1'b1 || start !== 1'b0) begin
      bad++; $display("FAIL rstmid_abort: got v=%b r=%b s=%b, required 0 1 0", valid_out, ready_in, start);
    end
    rst = 1'b0;
    @(negedge clk_in);
    clear_mon();
    run_frame(1'b0, 1'b0);
    drain();
    total++;
    if (beats.size() != 16 || fd_cnt != 1) begin
      bad++; $display("FAIL rstmid_count: got %0d beats fd=%0d, required 16 1", beats.size(), fd_cnt);
    end
    for (int k = 0; k < 16 && k < beats.size(); k++) begin
      total++;
      if (beats[k] !== 8'(exp_idx(k)) || starts[k] !== (k % 4 == 0)) begin
        bad++; $display("FAIL rstmid_beat%0d: got %h, required %h", k, beats[k], 8'(exp_idx(k)));
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] e;
    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    pix[0] = 8'hFF; pix[1] = 8'h00; pix[4] = 8'h00; pix[5] = 8'hFF;
    clear_mon();
    run_frame(1'b0, 1'b0);
    drain();
    total++;
    if (beats.size() != 16) begin
      bad++; $display("FAIL ext_count: got %0d beats, required 16", beats.size());
    end
    for (int k = 0; k < 16 && k < beats.size(); k++) begin
      e = pix[exp_idx(k)];
      total++;
      if (beats[k] !== e) begin
        bad++; $display("FAIL ext_beat%0d: got %h, required %h", k, beats[k], e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    @(negedge clk_in);
    test_reset();
    test_basic();
    test_toggle();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_window_buffer.md
Name: pool_window_buffer

Overview:
- Upstream feeder for the max-pooling stage: accepts a feature map in raster order, one pixel per handshake, and re-orders it into 2x2 pooling windows.
- Each window is emitted as 4 consecutive beats with a start pulse on the first beat, matching the pooling stage's 4-sample input convention.
- Holds one full even row in an internal line buffer and throttles upstream with ready_in while a window is being emitted.

Parameters:
- bits, 8, pixel width (unsigned).
- img_width, 8, pixels per row; even, >= 2.
- img_height, 8, rows per frame; even, >= 2.
- col_bits, 3, counter width; 2**col_bits >= img_width.
- row_bits, 3, counter width; 2**row_bits >= img_height.

Ports:
- clk_in  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  bits  pixel, raster order.
- valid_in  input  1  data_in valid.
- ready_in  output  1  block can accept; transfer occurs when valid_in && ready_in.
- data_out  output  bits  window sample.
- valid_out  output  1  data_out valid (4-cycle bursts).
- start  output  1  one-cycle pulse on the first beat of each window.
- frame_done  output  1  one-cycle pulse on the cycle after the final pixel of a frame is accepted.

Behaviour:
- Reset (rst=1 at a clock edge): data_out=0, valid_out=0, start=0, frame_done=0, ready_in=1, row/col counters=0, state=IDLE. Line-buffer contents are don't-care. Reset during an emission aborts it; valid_out is 0 on the next cycle.
- Counters: col increments per accepted pixel. At col=img_width-1, col wraps to 0 and row increments. At row=img_height-1 and col=img_width-1, both wrap to 0 and frame_done pulses the following cycle.
- Even row (row[0]=0): the accepted pixel is written to line_buf[col]. No output is produced.
- Odd row, even col: the pixel is stored in the hold register. No output is produced.
- Odd row, odd col: the accept at cycle T moves IDLE->EMIT.
  - Beats at T+1..T+4: line_buf[col-1], line_buf[col], hold, current pixel (top-left, top-right, bottom-left, bottom-right).
  - valid_out=1 for T+1..T+4. start=1 at T+1 only.
  - The current pixel is captured at T, so upstream may change data_in after T.
- ready_in is 0 for T+1..T+3 and 1 again at T+4. A pixel accepted at T+4 is always even-col, so it never overlaps an emission.
- States: IDLE (ready_in=1, waiting) and EMIT (beat counter 0..3; returns to IDLE after beat 3).
- valid_in while ready_in=0 is not accepted and changes no state; upstream holds data.
- Gaps in valid_in at any point are tolerated; counters advance only on transfers.
- data_out holds its last value when valid_out=0. Values pass through unmodified, with no arithmetic.
- Latency: 1 cycle from the bottom-right accept to the first beat. Sustained throughput is 1 pixel/cycle on even rows; on odd rows a 4-cycle emission follows each odd-col pixel.
- Back-to-back frames: row 0 of frame N+1 may be accepted at T+4 of the last window of frame N. Writes of the new row 0 must not corrupt the beats still being read; the read of beat 1 (line_buf[col]) completes before any new write to that index.

Test Plan:
- 4x4 frame, pixels 0..15, valid_in held 1 → windows (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15). Each window has start on its first beat and 4 valid_out cycles. frame_done pulses once, one cycle after pixel 15.
- Same frame with valid_in toggling 1,0 each cycle → identical output sequence; no beat lost or duplicated.
- valid_in held 1 with data changing every cycle during EMIT → ready_in=0 for exactly 3 cycles after each odd-row odd-col accept. Non-accepted data is not consumed; the next accepted pixel is the held value.
- Two 4x4 frames back-to-back (second frame 100..115) → frame 2 windows (100,101,104,105)..(110,111,114,115). There is no stale frame-1 data, and frame_done pulses twice.
- rst=1 asserted at beat 2 of window (2,3,6,7) → valid_out=0 next cycle and ready_in=1. A new frame 0..15 is then emitted correctly from window (0,1,4,5).
- Pixel values 0xFF and 0x00 in a mixed window (255,0,0,255) → emitted bit-exact with no sign or width change.
